// File: rtl/band_mixer_if.sv
`default_nettype none
// ============================================================================
// band_mixer_if : band sample/gain inputs and mixed-sample outputs
// Rev 1.0
// ============================================================================
interface band_mixer_if #(
  parameter int NUM_BANDS = 8,
  parameter int GAIN_W    = 8
);
  logic [NUM_BANDS*16-1:0]     band_data;
  logic [NUM_BANDS-1:0]        band_valid;
  logic [NUM_BANDS*GAIN_W-1:0] band_gain;
  logic [15:0]                 mix_out;
  logic                        mix_valid;
  logic                        overrun;

  modport master (
    output band_data, band_valid, band_gain,
    input  mix_out, mix_valid, overrun
  );

  modport slave (
    input  band_data, band_valid, band_gain,
    output mix_out, mix_valid, overrun
  );
endinterface
`default_nettype wire

// File: rtl/band_mixer.sv
`default_nettype none
// ============================================================================
// band_mixer : per-band gain and saturating sum using one shared multiplier
// Rev 1.0
// ============================================================================
module band_mixer #(
  parameter int NUM_BANDS  = 8,
  parameter int GAIN_W     = 8,
  parameter int GAIN_SHIFT = 7
) (
  input  logic         clk,
  input  logic         rst,
  band_mixer_if.slave  bus
);

  localparam int c_IDX_W  = $clog2(NUM_BANDS);
  localparam int c_PROD_W = 16 + GAIN_W + 1;
  localparam int c_ACC_W  = 16 + GAIN_W + 1 + $clog2(NUM_BANDS);
  localparam logic signed [c_ACC_W-1:0] c_MAX = c_ACC_W'(32767);
  localparam logic signed [c_ACC_W-1:0] c_MIN = -c_ACC_W'(32768);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MAC  = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;

  logic [1:0]                  r_state;
  logic [NUM_BANDS-1:0]        r_mask;
  logic signed [15:0]          r_cap  [NUM_BANDS];
  logic signed [15:0]          r_snap [NUM_BANDS];
  logic [NUM_BANDS*GAIN_W-1:0] r_gain_snap;
  logic signed [c_ACC_W-1:0]   r_acc;
  logic [c_IDX_W-1:0]          r_idx;
  logic [15:0]                 r_mix_out;
  logic                        r_mix_valid;
  logic                        r_overrun;

  logic                        w_take;
  logic [GAIN_W-1:0]           w_gain;
  logic signed [c_PROD_W-1:0]  w_prod;
  logic signed [c_ACC_W-1:0]   w_shifted;
  logic [15:0]                 w_sat;

  assign w_take    = (r_state == S_IDLE) && (&r_mask);
  assign w_gain    = r_gain_snap[int'(r_idx)*GAIN_W +: GAIN_W];
  // Gain is zero-extended so the product stays a signed x unsigned multiply.
  assign w_prod    = r_snap[r_idx] * $signed({1'b0, w_gain});
  assign w_shifted = r_acc >>> GAIN_SHIFT;

  always_comb begin
    w_sat = w_shifted[15:0];
    if (w_shifted > c_MAX)
      w_sat = 16'h7FFF;
    else if (w_shifted < c_MIN)
      w_sat = 16'h8000;
  end

  // A strobe landing on the snapshot edge starts the next frame, not an overrun.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mask    <= '0;
      r_overrun <= 1'b0;
      for (int i = 0; i < NUM_BANDS; i++)
        r_cap[i] <= '0;
    end else begin
      r_mask <= (w_take ? '0 : r_mask) | bus.band_valid;
      if (!w_take && (|(bus.band_valid & r_mask)))
        r_overrun <= 1'b1;
      for (int i = 0; i < NUM_BANDS; i++)
        if (bus.band_valid[i])
          r_cap[i] <= bus.band_data[16*i +: 16];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_gain_snap <= '0;
      r_acc       <= '0;
      r_idx       <= '0;
      r_mix_out   <= '0;
      r_mix_valid <= 1'b0;
      for (int i = 0; i < NUM_BANDS; i++)
        r_snap[i] <= '0;
    end else begin
      r_mix_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_take) begin
            r_snap      <= r_cap;
            r_gain_snap <= bus.band_gain;
            r_acc       <= '0;
            r_idx       <= '0;
            r_state     <= S_MAC;
          end
        end
        S_MAC: begin
          r_acc <= r_acc + w_prod;
          if (r_idx == c_IDX_W'(NUM_BANDS - 1))
            r_state <= S_OUT;
          else
            r_idx <= r_idx + 1'b1;
        end
        S_OUT: begin
          r_mix_out   <= w_sat;
          r_mix_valid <= 1'b1;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.mix_out   = r_mix_out;
  assign bus.mix_valid = r_mix_valid;
  assign bus.overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_band_mixer.sv
`default_nettype none
// ============================================================================
// tb_band_mixer : randomized scoreboard bench for band_mixer
// Rev 1.0
// ============================================================================
module tb_band_mixer;
  localparam int NB = 8;
  localparam int GW = 8;
  localparam int GS = 7;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  band_mixer_if #(.NUM_BANDS(NB), .GAIN_W(GW)) bus ();

  band_mixer #(.NUM_BANDS(NB), .GAIN_W(GW), .GAIN_SHIFT(GS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int value;
    int last_cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   latest [NB];
  bit   pending[NB];
  int   gains  [NB];
  int   sv     [NB];
  bit   exp_ovr = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Mix of the most recent sample per band: weighted sum, floor divide, clamp.
  function automatic int ref_mix();
    longint s = 0;
    for (int i = 0; i < NB; i++) s += longint'(latest[i]) * longint'(gains[i]);
    s = s >>> GS;
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    return int'(s);
  endfunction

  // One clock cycle of stimulus; strobes the bands in m with values sv[].
  task automatic step(input logic [NB-1:0] m);
    bit full;
    @(posedge clk);
    #1;
    for (int i = 0; i < NB; i++) begin
      bus.band_gain[GW*i +: GW] = GW'(gains[i]);
      if (m[i]) bus.band_data[16*i +: 16] = 16'(sv[i]);
    end
    bus.band_valid = m;
    for (int i = 0; i < NB; i++)
      if (m[i]) begin
        if (pending[i]) exp_ovr = 1'b1;
        latest[i]  = sv[i];
        pending[i] = 1'b1;
      end
    full = 1'b1;
    for (int i = 0; i < NB; i++) full &= pending[i];
    if (full) begin
      sb.push_back('{value: ref_mix(), last_cyc: cyc});
      for (int i = 0; i < NB; i++) pending[i] = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      step('0);
      n++;
    end
    if (sb.size() != 0) begin
      check("drain_timeout", sb.size(), 0);
      sb.delete();
    end
    step('0);
    check("overrun", bus.overrun, exp_ovr);
  endtask

  task automatic all_frame(input int val);
    for (int i = 0; i < NB; i++) sv[i] = val;
    step('1);
    wait_drain();
  endtask

  task automatic set_gains(input int g);
    for (int i = 0; i < NB; i++) gains[i] = g;
  endtask

  function automatic int rnd16();
    return int'($signed(16'($urandom)));
  endfunction

  // Monitor: pops the scoreboard on every mix_valid and checks hold/width/latency.
  int last_out = 0;
  bit prev_v   = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      last_out = 0;
      prev_v   = 1'b0;
    end else begin
      if (bus.mix_valid) begin
        check("mix_valid_single", prev_v, 0);
        if (sb.size() == 0) begin
          check("unexpected_mix_valid", 0, 1);
        end else begin
          e = sb.pop_front();
          check("mix_out", longint'($signed(bus.mix_out)), e.value);
          check("latency", cyc - e.last_cyc, NB + 3);
          last_out = e.value;
        end
      end else begin
        check("mix_out_hold", longint'($signed(bus.mix_out)), last_out);
      end
      prev_v = bus.mix_valid;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [NB-1:0] rem;
    logic [NB-1:0] m;
    rst = 1'b1;
    bus.band_data  = '0;
    bus.band_valid = '0;
    bus.band_gain  = '0;
    for (int i = 0; i < NB; i++) begin
      latest[i] = 0; pending[i] = 1'b0; gains[i] = 0; sv[i] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    check("reset_mix_out", bus.mix_out, 0);
    check("reset_mix_valid", bus.mix_valid, 0);
    check("reset_overrun", bus.overrun, 0);
    rst = 1'b0;

    // Unity, half gain, floor rounding, saturation.
    set_gains(128);
    all_frame(1000);
    set_gains(0); gains[0] = 64;
    for (int i = 0; i < NB; i++) sv[i] = rnd16();
    sv[0] = 1000; step('1); wait_drain();
    sv[0] = -3;   step('1); wait_drain();
    set_gains(128);
    all_frame(20000);
    all_frame(-20000);
    set_gains(255);
    all_frame(32767);

    // Band 2 strobed on the snapshot edge belongs to the following frame.
    set_gains(128);
    for (int i = 0; i < NB; i++) sv[i] = 1000;
    step('1);
    sv[2] = 777;
    step(NB'(1) << 2);
    wait_drain();
    for (int i = 0; i < NB; i++) if (i != 2) sv[i] = rnd16();
    step(~(NB'(1) << 2));
    wait_drain();

    // Staggered arrivals with band 3 overwritten before the frame completes.
    for (int i = 0; i < NB; i++) begin gains[i] = int'($urandom_range(0, 255)); sv[i] = rnd16(); end
    sv[3] = 100;
    for (int b = 0; b < NB; b++) begin
      step(NB'(1) << b);
      if (b < NB - 1)
        for (int k = 0; k < 4; k++) begin
          if (b == 3 && k == 1) begin sv[3] = 200; step(NB'(1) << 3); end
          else step('0);
        end
    end
    wait_drain();

    // Random frames: random gains, values and arrival order; overrun stays set.
    for (int f = 0; f < 12; f++) begin
      for (int i = 0; i < NB; i++) begin gains[i] = int'($urandom_range(0, 255)); sv[i] = rnd16(); end
      rem = '1;
      for (int n = 0; n < 64 && rem != '0; n++) begin
        m = (n == 63) ? rem : (NB'($urandom) & rem);
        step(m);
        rem &= ~m;
      end
      wait_drain();
    end

    // Reset during the third MAC cycle discards the frame and clears overrun.
    set_gains(128);
    for (int i = 0; i < NB; i++) sv[i] = 1234;
    step('1);
    step('0); step('0); step('0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    sb.delete();
    for (int i = 0; i < NB; i++) pending[i] = 1'b0;
    exp_ovr = 1'b0;
    #3;
    check("rst_mid_mac_mix_out", bus.mix_out, 0);
    check("rst_mid_mac_overrun", bus.overrun, 0);
    check("rst_mid_mac_mix_valid", bus.mix_valid, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (20) step('0);
    all_frame(1000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
